// File: rtl/sb_pkg.sv
// Shared sideband definitions: symbol field layout, control byte codes and rx framer states.
package sb_pkg;

    localparam int unsigned SYM_W     = 10;
    localparam int unsigned START_BIT = 0;
    localparam int unsigned DATA_LSB  = 1;
    localparam int unsigned DATA_MSB  = 8;
    localparam int unsigned STOP_BIT  = 9;

    localparam logic [7:0] DLE     = 8'hFE;
    localparam logic [7:0] STX_CMD = 8'h05;
    localparam logic [7:0] STX_RSP = 8'h04;
    localparam logic [7:0] ETX     = 8'h40;
    localparam logic [7:0] LSE     = 8'h80;
    localparam logic [7:0] CLSE    = 8'h7F;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/sb_line_monitor.sv
// Sideband line monitor: tracks consecutive high/low runs on the synchronized line
// and raises sticky, mutually exclusive connect/disconnect levels.
module sb_line_monitor
    import sb_pkg::*;
#(
    parameter int unsigned T_CONNECT_CYC    = 64,
    parameter int unsigned T_DISCONNECT_CYC = 128
) (
    input  logic sb_clk,
    input  logic rst,
    input  logic rx_s,
    output logic tconnect,
    output logic tdisconnect
);

    localparam int unsigned HI_W = $clog2(T_CONNECT_CYC + 1);
    localparam int unsigned LO_W = $clog2(T_DISCONNECT_CYC + 1);
    localparam logic [HI_W-1:0] HI_MAX = HI_W'(T_CONNECT_CYC);
    localparam logic [HI_W-1:0] HI_HIT = HI_W'(T_CONNECT_CYC - 1);
    localparam logic [LO_W-1:0] LO_MAX = LO_W'(T_DISCONNECT_CYC);
    localparam logic [LO_W-1:0] LO_HIT = LO_W'(T_DISCONNECT_CYC - 1);

    logic [HI_W-1:0] hi_cnt;
    logic [LO_W-1:0] lo_cnt;

    // Run counters saturate at their threshold; the level flips on the cycle the run reaches it.
    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            tconnect    <= 1'b0;
            tdisconnect <= 1'b0;
        end else if (rx_s) begin
            lo_cnt <= '0;
            if (hi_cnt != HI_MAX) hi_cnt <= hi_cnt + 1'b1;
            if (hi_cnt >= HI_HIT) begin
                tconnect    <= 1'b1;
                tdisconnect <= 1'b0;
            end
        end else begin
            hi_cnt <= '0;
            if (lo_cnt != LO_MAX) lo_cnt <= lo_cnt + 1'b1;
            if (lo_cnt >= LO_HIT) begin
                tdisconnect <= 1'b1;
                tconnect    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sb_rx_deserializer.sv
// Sideband receive front end: synchronizes the raw line, frames 10-bit UART-style
// symbols with OVS-times oversampling and reports framing errors and line state.
module sb_rx_deserializer
    import sb_pkg::*;
#(
    parameter int unsigned OVS              = 4,
    parameter int unsigned T_CONNECT_CYC    = 64,
    parameter int unsigned T_DISCONNECT_CYC = 128
) (
    input  logic             sb_clk,
    input  logic             rst,
    input  logic             sb_rx,
    input  logic             rx_en,
    output logic [SYM_W-1:0] sbrx,
    output logic             sym_valid,
    output logic             error,
    output logic             tconnect,
    output logic             tdisconnect
);

    localparam int unsigned PH_W = $clog2(OVS);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2 - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
    localparam logic [2:0]      BIT_LAST = 3'(DATA_MSB - DATA_LSB);

    logic            sync1, rx_s, rx_q;
    logic            fall_c;
    rx_state_e       state, state_nxt;
    logic [PH_W-1:0] phase, phase_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [7:0]      data_q, data_nxt;
    logic            armed, armed_nxt;
    logic [PH_W-1:0] arm_cnt, arm_cnt_nxt;
    logic [SYM_W-1:0] sbrx_nxt;
    logic            sym_valid_nxt, error_nxt;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle-high preset.
    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            sync1 <= sb_rx;
            rx_s  <= sync1;
            rx_q  <= rx_s;
        end
    end

    assign fall_c = rx_q & ~rx_s;

    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            state     <= RX_IDLE;
            phase     <= '0;
            bit_idx   <= '0;
            data_q    <= '0;
            armed     <= 1'b1;
            arm_cnt   <= '0;
            sbrx      <= '1;
            sym_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            bit_idx   <= bit_nxt;
            data_q    <= data_nxt;
            armed     <= armed_nxt;
            arm_cnt   <= arm_cnt_nxt;
            sbrx      <= sbrx_nxt;
            sym_valid <= sym_valid_nxt;
            error     <= error_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        phase_nxt     = (phase == PH_LAST) ? '0 : phase + 1'b1;
        bit_nxt       = bit_idx;
        data_nxt      = data_q;
        sbrx_nxt      = sbrx;
        sym_valid_nxt = 1'b0;
        error_nxt     = 1'b0;
        armed_nxt     = armed;
        arm_cnt_nxt   = arm_cnt;

        if (!rx_en) begin
            state_nxt = RX_IDLE;
            phase_nxt = '0;
            bit_nxt   = '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    phase_nxt = '0;
                    bit_nxt   = '0;
                    if (armed && fall_c) state_nxt = RX_START;
                end
                RX_START: begin
                    if (phase == PH_MID && rx_s) state_nxt = RX_IDLE;
                    else if (phase == PH_LAST)   state_nxt = RX_DATA;
                end
                RX_DATA: begin
                    if (phase == PH_MID) data_nxt = {rx_s, data_q[7:1]};
                    if (phase == PH_LAST) begin
                        if (bit_idx == BIT_LAST) state_nxt = RX_STOP;
                        else                     bit_nxt   = bit_idx + 1'b1;
                    end
                end
                RX_STOP: begin
                    // Leave at the stop mid-sample so a start bit right after the stop bit is caught.
                    if (phase == PH_MID) begin
                        sbrx_nxt[STOP_BIT]          = rx_s;
                        sbrx_nxt[DATA_MSB:DATA_LSB] = data_q;
                        sbrx_nxt[START_BIT]         = 1'b0;
                        sym_valid_nxt               = 1'b1;
                        error_nxt                   = ~rx_s;
                        state_nxt                   = RX_IDLE;
                    end
                end
                default: state_nxt = RX_IDLE;
            endcase
        end

        // Break lockout: a framing error disarms until the line has been high for a full bit.
        if (error_nxt) begin
            armed_nxt   = 1'b0;
            arm_cnt_nxt = '0;
        end else if (!armed) begin
            if (!rx_s) begin
                arm_cnt_nxt = '0;
            end else if (arm_cnt == PH_LAST) begin
                armed_nxt   = 1'b1;
                arm_cnt_nxt = '0;
            end else begin
                arm_cnt_nxt = arm_cnt + 1'b1;
            end
        end
    end

    sb_line_monitor #(
        .T_CONNECT_CYC   (T_CONNECT_CYC),
        .T_DISCONNECT_CYC(T_DISCONNECT_CYC)
    ) u_line_monitor (
        .sb_clk     (sb_clk),
        .rst        (rst),
        .rx_s       (rx_s),
        .tconnect   (tconnect),
        .tdisconnect(tdisconnect)
    );

endmodule

// File: tb/tb_sb_rx_deserializer.sv
// Bench for sb_rx_deserializer: directed and random frames, checked every cycle against
// a frame-level expectation queue and a run-length model of the line monitor.
module tb_sb_rx_deserializer;
    import sb_pkg::*;

    localparam int unsigned OVS = 4;
    localparam int unsigned TC  = 64;
    localparam int unsigned TD  = 128;
    // sb_rx -> rx_s is two clocks, the FSM registers the start edge one clock later,
    // then the strobe follows after 9*OVS + OVS/2 clocks.
    localparam int unsigned LAT = 3 + 9 * OVS + OVS / 2;

    logic       sb_clk = 1'b0;
    logic       rst, sb_rx, rx_en;
    logic [9:0] sbrx;
    logic       sym_valid, error, tconnect, tdisconnect;

    always #5 sb_clk = ~sb_clk;

    sb_rx_deserializer #(
        .OVS(OVS), .T_CONNECT_CYC(TC), .T_DISCONNECT_CYC(TD)
    ) dut (
        .sb_clk(sb_clk), .rst(rst), .sb_rx(sb_rx), .rx_en(rx_en),
        .sbrx(sbrx), .sym_valid(sym_valid), .error(error),
        .tconnect(tconnect), .tdisconnect(tdisconnect)
    );

    typedef struct {
        int         cyc;
        logic [9:0] sym;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model state: rx_s delay line and current line run.
    logic m_s1, m_rxs, m_lvl, m_con, m_dis;
    int   m_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic tick();
        exp_t e;
        if (rst) begin
            m_s1 = 1'b1; m_rxs = 1'b1; m_lvl = 1'b1; m_run = 0; m_con = 1'b0; m_dis = 1'b0;
        end else begin
            if (m_rxs == m_lvl) m_run++;
            else begin m_lvl = m_rxs; m_run = 1; end
            if (m_lvl && m_run >= int'(TC))  begin m_con = 1'b1; m_dis = 1'b0; end
            if (!m_lvl && m_run >= int'(TD)) begin m_dis = 1'b1; m_con = 1'b0; end
            m_rxs = m_s1;
            m_s1  = sb_rx;
        end
        @(posedge sb_clk);
        #1;
        cyc++;
        check("tconnect", 32'(tconnect), 32'(m_con));
        check("tdisconnect", 32'(tdisconnect), 32'(m_dis));
        if (sym_valid) begin
            check("strobe_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("strobe_cycle", 32'(cyc), 32'(e.cyc));
                check("sbrx", 32'(sbrx), 32'(e.sym));
                check("error", 32'(error), 32'(e.err));
            end
        end else begin
            check("error_alone", 32'(error), 32'd0);
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                check("strobe_missing", 32'(cyc), 32'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic idle_bits(input int n);
        sb_rx = 1'b1;
        repeat (n * int'(OVS)) tick();
    endtask

    // abort_kind: 0 none, 1 reset pulse, 2 rx_en drop, applied at data bit abort_bit.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int abort_bit, input int abort_kind);
        exp_t e;
        bit   aborted = 0;
        if (abort_kind == 0) begin
            e.cyc = cyc + int'(LAT);
            e.sym = {stop, d, 1'b0};
            e.err = ~stop;
            exp_q.push_back(e);
        end
        sb_rx = 1'b0;
        repeat (OVS) tick();
        for (int k = 0; k < 8 && !aborted; k++) begin
            if (abort_kind != 0 && k == abort_bit) begin
                aborted = 1;
                sb_rx = 1'b1;
                if (abort_kind == 1) begin
                    rst = 1'b1;
                    repeat (2) tick();
                    rst = 1'b0;
                end else begin
                    rx_en = 1'b0;
                    repeat (OVS) tick();
                    rx_en = 1'b1;
                end
            end else begin
                sb_rx = d[k];
                repeat (OVS) tick();
            end
        end
        if (!aborted) begin
            sb_rx = stop;
            repeat (OVS) tick();
        end
    endtask

    logic [7:0] pool [6];
    logic [7:0] rd;

    initial begin
        pool = '{DLE, STX_CMD, STX_RSP, ETX, LSE, CLSE};
        rst = 1'b1; sb_rx = 1'b1; rx_en = 1'b1;
        repeat (3) tick();
        check("rst_sbrx", 32'(sbrx), 32'h3FF);
        check("rst_sym_valid", 32'(sym_valid), 32'd0);
        check("rst_tconnect", 32'(tconnect), 32'd0);
        check("rst_tdisconnect", 32'(tdisconnect), 32'd0);
        rst = 1'b0;

        // Line idle high from reset: connect after TC high cycles.
        repeat (TC - 1) tick();
        check("connect_not_yet", 32'(tconnect), 32'd0);
        tick();
        check("connect_at_threshold", 32'(tconnect), 32'd1);
        idle_bits(2);

        // Single frame, then back-to-back pair.
        send_frame(DLE, 1'b1, -1, 0);
        idle_bits(3);
        send_frame(STX_CMD, 1'b1, -1, 0);
        send_frame(ETX, 1'b1, -1, 0);
        idle_bits(3);

        // Framing error followed by a held-low line: one error only, then disconnect.
        send_frame(8'hA5, 1'b0, -1, 0);
        sb_rx = 1'b0;
        repeat (TD + 20) tick();
        check("disconnect_held_low", 32'(tdisconnect), 32'd1);
        check("connect_cleared", 32'(tconnect), 32'd0);
        idle_bits(20);

        // Two-cycle low glitch is a false start; a following frame is still received.
        sb_rx = 1'b0;
        repeat (2) tick();
        idle_bits(3);
        send_frame(STX_RSP, 1'b1, -1, 0);
        idle_bits(2);

        // Reset and rx_en aborts at data bit 4, each followed by a clean LSE frame.
        send_frame(8'($urandom), 1'b1, 4, 1);
        idle_bits(3);
        send_frame(LSE, 1'b1, -1, 0);
        idle_bits(2);
        send_frame(8'($urandom), 1'b1, 4, 2);
        idle_bits(2);
        send_frame(LSE, 1'b1, -1, 0);
        idle_bits(2);

        // Error with a short high gap (one bit re-arms), then a good frame.
        send_frame(8'($urandom), 1'b0, -1, 0);
        idle_bits(2);
        send_frame(CLSE, 1'b1, -1, 0);

        // Random frames with random gaps, including none.
        for (int i = 0; i < 24; i++) begin
            rd = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : 8'($urandom);
            idle_bits(int'($urandom_range(0, 2)));
            send_frame(rd, 1'b1, -1, 0);
        end
        idle_bits(12);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
